// File: rtl/sys_priv_pkg.sv
// Shared constants and types for the system privilege controller.
package sys_priv_pkg;

    localparam int LEVEL_SYS = 0;

    typedef enum logic [1:0] {
        FAULT_NONE = 2'd0,
        FAULT_OVF  = 2'd1,
        FAULT_UNF  = 2'd2,
        FAULT_ILL  = 2'd3
    } fault_cause_e;

endpackage

// File: rtl/sys_priv_lifo.sv
// Small LIFO holding the privilege levels interrupted by nested traps.
module sys_priv_lifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           top_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MEM_N = 2 ** IDX_W;

    logic [WIDTH-1:0] mem_q [MEM_N];
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign top_idx = count_q - CNT_W'(1);
    assign wr_idx  = count_q[IDX_W-1:0];
    assign rd_idx  = top_idx[IDX_W-1:0];
    assign top_o   = empty_o ? '0 : mem_q[rd_idx];

    // Push has precedence; the caller never requests both in one cycle.
    always_comb begin
        count_d = count_q;
        if (push_i && !full_o) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_i && !empty_o) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is not reset: only the count defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/sys_priv_stack.sv
// Privilege register with trap entry/return arbitration and fault reporting.
module sys_priv_stack
    import sys_priv_pkg::*;
#(
    parameter int LEVEL_W = 2,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       priv_we,
    input  logic [LEVEL_W-1:0]         priv_level,
    input  logic                       to_sys,
    input  logic                       sys_ret,
    output logic [LEVEL_W-1:0]         privilage,
    output logic                       is_sys,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       fault,
    output logic [1:0]                 fault_cause
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [LEVEL_W-1:0] priv_q, priv_d, tos;
    logic               fault_q, fault_d;
    fault_cause_e       cause_q, cause_d;
    logic               push, pop, full, empty;
    logic [CNT_W-1:0]   cnt;

    sys_priv_lifo #(
        .WIDTH (LEVEL_W),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (priv_q),
        .top_o   (tos),
        .count_o (cnt),
        .full_o  (full),
        .empty_o (empty)
    );

    // Trap entry beats return beats explicit write; losers are dropped quietly.
    always_comb begin
        priv_d  = priv_q;
        fault_d = 1'b0;
        cause_d = cause_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (to_sys) begin
            priv_d = LEVEL_W'(LEVEL_SYS);
            if (full) begin
                fault_d = 1'b1;
                cause_d = FAULT_OVF;
            end else begin
                push = 1'b1;
            end
        end else if (sys_ret) begin
            if (empty) begin
                fault_d = 1'b1;
                cause_d = FAULT_UNF;
            end else begin
                pop    = 1'b1;
                priv_d = tos;
            end
        end else if (priv_we) begin
            if (priv_q == LEVEL_W'(LEVEL_SYS)) begin
                priv_d = priv_level;
            end else begin
                fault_d = 1'b1;
                cause_d = FAULT_ILL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            priv_q  <= LEVEL_W'(LEVEL_SYS);
            fault_q <= 1'b0;
            cause_q <= FAULT_NONE;
        end else begin
            priv_q  <= priv_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    assign privilage   = priv_q;
    assign is_sys      = (priv_q == LEVEL_W'(LEVEL_SYS));
    assign depth       = cnt;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_sys_priv_stack.sv
// Bench for sys_priv_stack: queue-based reference model plus directed literal checks.
module tb_sys_priv_stack;

    localparam int D0 = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Instance A: LEVEL_W=2, DEPTH=4
    logic       a_we = 0, a_ts = 0, a_sr = 0;
    logic [1:0] a_lv = 0;
    logic [1:0] a_priv, a_cause;
    logic [2:0] a_depth;
    logic       a_is_sys, a_full, a_empty, a_fault;

    // Instance B: LEVEL_W=3, DEPTH=1
    logic       b_we = 0, b_ts = 0, b_sr = 0;
    logic [2:0] b_lv = 0;
    logic [2:0] b_priv;
    logic [1:0] b_cause;
    logic [0:0] b_depth;
    logic       b_is_sys, b_full, b_empty, b_fault;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    // Reference model state for instance A
    int m_stk[$];
    int m_lvl, m_fault, m_cause;

    always #5 clk = ~clk;

    sys_priv_stack #(.LEVEL_W(2), .DEPTH(D0)) u_a (
        .clk(clk), .rst(rst), .priv_we(a_we), .priv_level(a_lv),
        .to_sys(a_ts), .sys_ret(a_sr), .privilage(a_priv), .is_sys(a_is_sys),
        .depth(a_depth), .stack_full(a_full), .stack_empty(a_empty),
        .fault(a_fault), .fault_cause(a_cause)
    );

    sys_priv_stack #(.LEVEL_W(3), .DEPTH(1)) u_b (
        .clk(clk), .rst(rst), .priv_we(b_we), .priv_level(b_lv),
        .to_sys(b_ts), .sys_ret(b_sr), .privilage(b_priv), .is_sys(b_is_sys),
        .depth(b_depth), .stack_full(b_full), .stack_empty(b_empty),
        .fault(b_fault), .fault_cause(b_cause)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one request per cycle resolved by priority, stack as a queue.
    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_stk.delete();
            m_lvl = 0; m_fault = 0; m_cause = 0;
        end else begin
            m_fault = 0;
            if (a_ts) begin
                if (m_stk.size() < D0) m_stk.push_back(m_lvl);
                else begin m_fault = 1; m_cause = 1; end
                m_lvl = 0;
            end else if (a_sr) begin
                if (m_stk.size() > 0) m_lvl = m_stk.pop_back();
                else begin m_fault = 1; m_cause = 2; end
            end else if (a_we) begin
                if (m_lvl == 0) m_lvl = int'(a_lv);
                else begin m_fault = 1; m_cause = 3; end
            end
        end
        #1;
        if (chk_en) begin
            check("m.privilage", int'(a_priv), m_lvl);
            check("m.is_sys", int'(a_is_sys), int'(m_lvl == 0));
            check("m.depth", int'(a_depth), m_stk.size());
            check("m.full", int'(a_full), int'(m_stk.size() == D0));
            check("m.empty", int'(a_empty), int'(m_stk.size() == 0));
            check("m.fault", int'(a_fault), m_fault);
            check("m.cause", int'(a_cause), m_cause);
        end
    end

    task automatic op_a(input logic ts, input logic sr, input logic we, input logic [1:0] lv);
        @(negedge clk);
        a_ts = ts; a_sr = sr; a_we = we; a_lv = lv;
        @(posedge clk);
        #2;
        a_ts = 0; a_sr = 0; a_we = 0;
    endtask

    task automatic op_b(input logic ts, input logic sr, input logic we, input logic [2:0] lv);
        @(negedge clk);
        b_ts = ts; b_sr = sr; b_we = we; b_lv = lv;
        @(posedge clk);
        #2;
        b_ts = 0; b_sr = 0; b_we = 0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        @(negedge clk); @(negedge clk);
        rst = 0;
        chk_en = 1;
        check("rst.priv", int'(a_priv), 0);
        check("rst.depth", int'(a_depth), 0);
        check("rst.fault", int'(a_fault), 0);
        check("rst.cause", int'(a_cause), 0);
        check("rst.empty", int'(a_empty), 1);

        // Trap from system and return
        op_a(1, 0, 0, 0);
        check("t1.priv", int'(a_priv), 0);
        check("t1.depth", int'(a_depth), 1);
        op_a(0, 1, 0, 0);
        check("r1.depth", int'(a_depth), 0);
        check("r1.fault", int'(a_fault), 0);

        // Write 3, illegal write, two traps, two returns
        op_a(0, 0, 1, 3);
        check("w3.priv", int'(a_priv), 3);
        op_a(0, 0, 1, 1);
        check("ill.fault", int'(a_fault), 1);
        check("ill.cause", int'(a_cause), 3);
        check("ill.priv", int'(a_priv), 3);
        op_a(1, 0, 0, 0);
        op_a(1, 0, 0, 0);
        check("t2.depth", int'(a_depth), 2);
        op_a(0, 1, 0, 0);
        check("r2a.priv", int'(a_priv), 0);
        op_a(0, 1, 0, 0);
        check("r2b.priv", int'(a_priv), 3);
        check("r2b.depth", int'(a_depth), 0);

        // Overflow then underflow from level 2
        reset_pulse();
        op_a(0, 0, 1, 2);
        for (int i = 0; i < 5; i++) op_a(1, 0, 0, 0);
        check("ovf.depth", int'(a_depth), 4);
        check("ovf.full", int'(a_full), 1);
        check("ovf.fault", int'(a_fault), 1);
        check("ovf.cause", int'(a_cause), 1);
        check("ovf.priv", int'(a_priv), 0);
        op_a(0, 1, 0, 0); check("pop1", int'(a_priv), 0);
        op_a(0, 1, 0, 0); check("pop2", int'(a_priv), 0);
        op_a(0, 1, 0, 0); check("pop3", int'(a_priv), 0);
        op_a(0, 1, 0, 0); check("pop4", int'(a_priv), 2);
        op_a(0, 1, 0, 0);
        check("unf.fault", int'(a_fault), 1);
        check("unf.cause", int'(a_cause), 2);
        check("unf.priv", int'(a_priv), 2);

        // All three requests together at level 1, depth 0
        reset_pulse();
        op_a(0, 0, 1, 1);
        op_a(1, 1, 1, 2);
        check("all.priv", int'(a_priv), 0);
        check("all.depth", int'(a_depth), 1);
        check("all.fault", int'(a_fault), 0);

        // Build depth 3 at level 1, leave a fault cause, then async reset
        op_a(0, 0, 1, 1); op_a(1, 0, 0, 0);
        op_a(0, 0, 1, 1); op_a(1, 0, 0, 0);
        op_a(0, 0, 1, 1);
        op_a(0, 0, 1, 2);
        check("pre.depth", int'(a_depth), 3);
        check("pre.priv", int'(a_priv), 1);
        check("pre.cause", int'(a_cause), 3);
        @(posedge clk);
        #3 rst = 1;
        #1;
        check("arst.priv", int'(a_priv), 0);
        check("arst.depth", int'(a_depth), 0);
        check("arst.cause", int'(a_cause), 0);
        @(negedge clk);
        rst = 0;

        // Randomized traffic, model checks every cycle
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            a_ts = ($urandom_range(0, 99) < 30);
            a_sr = ($urandom_range(0, 99) < 30);
            a_we = ($urandom_range(0, 99) < 40);
            a_lv = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        a_ts = 0; a_sr = 0; a_we = 0;

        // Instance B: LEVEL_W=3, DEPTH=1
        reset_pulse();
        op_b(0, 0, 1, 7);
        check("b.w7", int'(b_priv), 7);
        op_b(1, 0, 0, 0);
        check("b.t1.priv", int'(b_priv), 0);
        check("b.t1.full", int'(b_full), 1);
        op_b(1, 0, 0, 0);
        check("b.ovf.fault", int'(b_fault), 1);
        check("b.ovf.cause", int'(b_cause), 1);
        check("b.ovf.depth", int'(b_depth), 1);
        op_b(0, 1, 0, 0);
        check("b.ret.priv", int'(b_priv), 7);
        check("b.ret.empty", int'(b_empty), 1);
        check("b.ret.fault", int'(b_fault), 0);
        check("b.ret.is_sys", int'(b_is_sys), 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sys_priv_stack.md
# sys_priv_stack

Parametrised system privilege controller with a nested-trap return stack. It holds the current privilege level and forces system level (0) on a trap, saving the interrupted level on a LIFO. On trap return it restores the saved level, and it only accepts explicit level writes while already in system mode. It sits beside the CPU control unit, feeding the current privilege level to the MMU and to instruction-legality checks.

## Interface
Parameters:
- LEVEL_W, 2: width of a privilege level; level 0 is system, larger values are less privileged.
- DEPTH, 4: maximum number of nested traps saved (≥1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- priv_we  in  1  request to set the level to priv_level.
- priv_level  in  LEVEL_W  level to write.
- to_sys  in  1  trap/interrupt entry: push the current level and enter system mode.
- sys_ret  in  1  trap return: pop the saved level.
- privilage  out  LEVEL_W  current privilege level (registered).
- is_sys  out  1  privilage == 0 (combinational from the register).
- depth  out  $clog2(DEPTH+1)  number of saved entries.
- stack_full  out  1  depth == DEPTH.
- stack_empty  out  1  depth == 0.
- fault  out  1  one-cycle pulse: a request was rejected.
- fault_cause  out  2  cause of the last fault: 0 none, 1 overflow, 2 underflow, 3 illegal write. Holds its value until the next fault or reset.

## Operation
- Reset (asynchronous) values:
  - privilage = 0, depth = 0, fault = 0, fault_cause = 0.
  - Stack contents are don't-care.
- Priority when several requests are high in one cycle: to_sys > sys_ret > priv_we.
  - Only the winning request acts.
  - Losing requests are dropped silently: no fault.
- to_sys:
  - depth < DEPTH: push privilage to stack[depth], depth+1, privilage ← 0.
  - depth == DEPTH: no push, depth unchanged, privilage ← 0, fault pulse, cause 1. Entering system mode is never blocked.
- sys_ret (and no to_sys):
  - depth > 0: privilage ← stack[depth−1], depth−1.
  - depth == 0: privilage unchanged, fault pulse, cause 2.
- priv_we (and no to_sys, no sys_ret):
  - privilage == 0: privilage ← priv_level. Stack untouched.
  - privilage ≠ 0: ignored, fault pulse, cause 3.
- Writing level 0 while in system mode is legal and has no effect.
- No request in a cycle: all state is held and fault = 0.

## Timing
- All outputs are registered except is_sys, stack_full and stack_empty, which decode registered state only.
- Latency: a request sampled at edge N is visible on privilage/depth after edge N; fault is high for exactly the cycle following edge N.
- Back-to-back to_sys/sys_ret on consecutive cycles are fully supported, one operation per cycle with no bubbles.
- A trap on the same cycle as a pop, with depth == DEPTH, is a push only (to_sys wins), so it overflows.
- Reset asserted mid-sequence clears everything immediately, independent of clk. The first operation is accepted on the first edge after rst deasserts.

## Structure
- Package sys_priv_pkg:
  - LEVEL_SYS = 0.
  - fault-cause constants FAULT_NONE/OVF/UNF/ILL as a 2-bit typedef.
- Sub-module sys_priv_lifo: parametrised LIFO (WIDTH = LEVEL_W, DEPTH).
  - push/pop ports, top-of-stack output, count, full, empty.
  - Reset clears the count only.
- Top level: priority arbitration, privilege register, fault logic.

## Test plan
- Reset, then to_sys with privilage 0 → privilage 0, depth 1; sys_ret → privilage 0, depth 0, no fault.
- In system mode, write priv_level 3; then to_sys ×2 with priv_we ignored in between (fault, cause 3) → after 2 sys_ret, privilage returns to 3, depth 0.
- DEPTH=4: five consecutive to_sys from level 2 → depth saturates at 4, fifth cycle gives fault with cause 1, privilage 0; four sys_ret restore 0,0,0,2 in order; a fifth sys_ret gives fault with cause 2, privilage stays 2.
- Same cycle to_sys+sys_ret+priv_we at level 1, depth 0 → push only: privilage 0, depth 1, no fault.
- Assert rst asynchronously between edges at depth 3, level 1 → privilage 0, depth 0, fault_cause 0 before the next edge.
- LEVEL_W=3, DEPTH=1: write 7, to_sys, to_sys → second trap overflows (cause 1); sys_ret restores 7.
